// File: rtl/seq_pkg.sv
// Shared definitions for the 1011 serial link (transmitter and detector side).
package seq_pkg;

   localparam int             PAT_W   = 4;
   localparam logic [PAT_W-1:0] PATTERN = 4'b1011;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PRE   = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STUFF = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_PRE   = ST_PRE,
      S_DATA  = ST_DATA,
      S_STUFF = ST_STUFF,
      S_GAP   = ST_GAP
   } state_e;

   // A 1 following these three line bits would complete the pattern.
   localparam logic [2:0] STUFF_HIST = 3'b101;

endpackage

// File: rtl/seq1011_tx.sv
// Serial frame transmitter: preamble 1011, zero-stuffed MSB-first payload, guard zeros.
// state | meaning
// IDLE  | line low, waiting for din_valid
// PRE   | driving the preamble bits
// DATA  | driving a payload bit
// STUFF | driving an inserted 0 (payload bit held back)
// GAP   | driving guard zeros before returning to IDLE
module seq1011_tx
   import seq_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int GAP    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              op,
   output logic              busy
);

   localparam int CW = $clog2(DATA_W + 1);
   localparam int GW = $clog2(GAP + 1);
   localparam int PW = $clog2(PAT_W + 1);

   localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);
   localparam logic [PW-1:0] PRE_LOAD = PW'(PAT_W - 1);

   state_e            state_q, state_d;
   logic              op_q, op_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [GW-1:0]     gcnt_q, gcnt_d;
   logic [PW-1:0]     pcnt_q, pcnt_d;
   logic [PAT_W-2:0]  pre_q, pre_d;
   logic [2:0]        hist_q, hist_d;

   always_comb begin
      state_d = state_q;
      op_d    = 1'b0;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      gcnt_d  = gcnt_q;
      pcnt_d  = pcnt_q;
      pre_d   = pre_q;
      unique case (state_q)
         S_IDLE: begin
            if (din_valid) begin
               state_d = S_PRE;
               op_d    = PATTERN[PAT_W-1];
               pre_d   = PATTERN[PAT_W-2:0];
               pcnt_d  = PRE_LOAD;
               shift_d = din;
               cnt_d   = '0;
            end
         end
         S_PRE, S_DATA, S_STUFF: begin
            if (state_q == S_PRE && pcnt_q != '0) begin
               op_d   = pre_q[PAT_W-2];
               pre_d  = pre_q << 1;
               pcnt_d = pcnt_q - 1'b1;
            end else if (cnt_q != CNT_LAST) begin
               // Stuff check happens only while payload bits remain.
               if (hist_q == STUFF_HIST) begin
                  state_d = S_STUFF;
                  op_d    = 1'b0;
               end else begin
                  state_d = S_DATA;
                  op_d    = shift_q[DATA_W-1];
                  shift_d = shift_q << 1;
                  cnt_d   = cnt_q + 1'b1;
               end
            end else begin
               state_d = S_GAP;
               op_d    = 1'b0;
               gcnt_d  = GAP_LOAD;
            end
         end
         S_GAP: begin
            if (gcnt_q != '0) begin
               gcnt_d = gcnt_q - 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      hist_d = (state_d == S_IDLE) ? 3'b000 : {hist_q[1:0], op_d};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         op_q    <= 1'b0;
         shift_q <= '0;
         cnt_q   <= '0;
         gcnt_q  <= '0;
         pcnt_q  <= '0;
         pre_q   <= '0;
         hist_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         gcnt_q  <= gcnt_d;
         pcnt_q  <= pcnt_d;
         pre_q   <= pre_d;
         hist_q  <= hist_d;
      end
   end

   assign op        = op_q;
   assign busy      = (state_q != S_IDLE);
   assign din_ready = (state_q == S_IDLE) && rst;

endmodule

// File: tb/tb_seq1011_tx.sv
// Bench for seq1011_tx: frame-rule reference model plus an overlapping 1011 receiver on op.
module tb_seq1011_tx;

   logic       clk;
   logic       rst;
   logic [7:0] din;
   logic       din_valid;
   logic       din_ready;
   logic       op;
   logic       busy;

   int checks = 0;
   int errors = 0;

   seq1011_tx #(.DATA_W(8), .GAP(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .op        (op),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Receiver: overlapping 1011 detector, then collects 8 payload bits,
   // dropping any bit that follows 1,0,1 on the line.
   int         det_count = 0;
   logic [3:0] rx_hist   = 4'b0000;
   bit         rx_act    = 1'b0;
   int         rx_n      = 0;
   logic [7:0] rx_word   = 8'h00;
   logic [7:0] rx_q[$];

   always @(negedge clk) begin
      logic [2:0] prev3;
      if (!rst) begin
         rx_hist = 4'b0000;
         rx_act  = 1'b0;
      end else begin
         prev3   = rx_hist[2:0];
         rx_hist = {rx_hist[2:0], op};
         if (rx_hist == 4'b1011) det_count++;
         if (rx_act) begin
            if (prev3 != 3'b101) begin
               rx_word = {rx_word[6:0], op};
               rx_n++;
               if (rx_n == 8) begin
                  rx_q.push_back(rx_word);
                  rx_act = 1'b0;
               end
            end
         end else if (rx_hist == 4'b1011) begin
            rx_act = 1'b1;
            rx_n   = 0;
         end
      end
   end

   bit exp_q[$];

   // Expected line bits for one frame, built directly from the frame rules.
   function automatic void build(input logic [7:0] w);
      int n;
      exp_q = {};
      exp_q.push_back(1'b1); exp_q.push_back(1'b0);
      exp_q.push_back(1'b1); exp_q.push_back(1'b1);
      for (int i = 7; i >= 0; i--) begin
         n = exp_q.size();
         if (exp_q[n-3] == 1'b1 && exp_q[n-2] == 1'b0 && exp_q[n-1] == 1'b1)
            exp_q.push_back(1'b0);
         exp_q.push_back(w[i]);
      end
      exp_q.push_back(1'b0);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called on a negedge with the DUT idle; returns on the negedge of the next idle cycle.
   task automatic run_frame(input logic [7:0] w, input bit keep, input logic [7:0] nxt,
                            input int lit_len, input logic [31:0] lit);
      int          d0;
      int          bc;
      logic [31:0] cap;
      logic [7:0]  got;
      check("ready_idle", din_ready, 1);
      check("busy_idle", busy, 0);
      build(w);
      d0  = det_count;
      cap = 0;
      bc  = 0;
      din       = w;
      din_valid = 1'b1;
      @(negedge clk);
      for (int i = 0; i < exp_q.size(); i++) begin
         check("op_bit", op, exp_q[i]);
         check("busy_frame", busy, 1);
         cap = {cap[30:0], op};
         bc  = bc + int'(busy);
         if (keep) begin
            din_valid = 1'b1;
            din       = nxt;
         end else begin
            din_valid = 1'($urandom_range(0, 1));
            din       = 8'($urandom);
         end
         @(negedge clk);
      end
      din_valid = keep;
      check("busy_end", busy, 0);
      check("op_end", op, 0);
      check("ready_end", din_ready, 1);
      check("detections", det_count - d0, 1);
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      check("payload", got, w);
      if (lit_len > 0) begin
         check("frame_bits", cap, lit);
         check("busy_cycles", bc, lit_len);
      end
   endtask

   initial begin
      logic [7:0] w;
      logic [7:0] nxt;
      bit         kv;
      int         d0;

      rst       = 1'b0;
      din       = 8'h5A;
      din_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rst_op", op, 0);
         check("rst_busy", busy, 0);
      end
      din_valid = 1'b0;
      rst       = 1'b1;
      #1;
      check("rel_ready", din_ready, 1);
      check("rel_busy", busy, 0);
      @(negedge clk);
      check("rel_no_accept", busy, 0);
      check("rel_no_det", det_count, 0);

      run_frame(8'hA5, 1'b0, 8'h00, 14, 32'b10111010001010);
      run_frame(8'hFF, 1'b0, 8'h00, 13, 32'b1011111111110);
      run_frame(8'hB0, 1'b0, 8'h00, 15, 32'b101110101000000);

      run_frame(8'h00, 1'b1, 8'h5A, 0, 0);
      run_frame(8'h5A, 1'b0, 8'h00, 0, 0);

      w = 8'($urandom);
      for (int i = 0; i < 20; i++) begin
         nxt = 8'($urandom);
         kv  = (i < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
         run_frame(w, kv, nxt, 0, 0);
         w = kv ? nxt : 8'($urandom);
      end

      // Abort a frame after three payload bits.
      d0 = det_count;
      build(8'hC3);
      din       = 8'hC3;
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         check("abort_op_bit", op, exp_q[i]);
         @(negedge clk);
      end
      rst = 1'b0;
      #1;
      check("abort_op", op, 0);
      check("abort_busy", busy, 0);
      @(negedge clk);
      check("abort_op_hold", op, 0);
      rst = 1'b1;
      #1;
      check("abort_no_payload", rx_q.size(), 0);
      check("abort_det", det_count - d0, 1);
      @(negedge clk);
      run_frame(8'($urandom), 1'b0, 8'h00, 0, 0);
      run_frame(8'hB0, 1'b0, 8'h00, 15, 32'b101110101000000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
